ifetch8: RTL and testbench
==========================

IFETCH8 -- requirements
Module: ifetch8

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 mem_req  output  1  instruction memory read request.
REQ-004 mem_addr  output  8  word address of the pending request.
REQ-005 mem_ack  input  1  memory accepted request; mem_data valid in the same cycle.
REQ-006 mem_data  input  16  instruction word returned by memory.
REQ-007 inst_valid  output  1  instruction queue non-empty.
REQ-008 inst  output  16  instruction at the queue head; drives the core IR input.
REQ-009 inst_take  input  1  core consumes the head (core IR load enable in fetch state).
REQ-010 branch  input  1  redirect fetch stream.
REQ-011 branch_addr  input  8  redirect target.
REQ-012 fetch_pc  output  8  address of the next word to be requested.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and DROP; mem_req SHALL be 1 exactly in WAIT and DROP.
REQ-014 Queue depth SHALL be 2 (first-in, first-out); credit SHALL be depth minus (count plus outstanding request).
REQ-015 IDLE -> WAIT when credit > 0 and branch=0; mem_addr SHALL be loaded with fetch_pc on that edge.
REQ-016 In WAIT/DROP, mem_addr SHALL be held stable until the mem_ack edge.
REQ-017 WAIT with mem_ack=1, branch=0: push mem_data, fetch_pc <= fetch_pc+1 (mod 256, 0xFF wraps to 0x00), -> IDLE.
REQ-018 Minimum spacing: one idle cycle between consecutive requests; peak throughput 1 word / 2 cycles.
REQ-019 Pushed word SHALL appear on inst with inst_valid=1 the cycle after the ack edge (1-cycle latency).
REQ-020 inst_take with inst_valid=1 SHALL pop the head; inst_take with inst_valid=0 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-022 Ack while queue full SHALL be impossible by the credit rule; no request is issued at credit 0.
REQ-023 branch in IDLE: flush queue, fetch_pc <= branch_addr, stay IDLE.
REQ-024 branch in WAIT, mem_ack=0: flush queue, fetch_pc <= branch_addr, -> DROP.
REQ-025 branch in WAIT or DROP with mem_ack=1: discard mem_data, flush queue, fetch_pc <= branch_addr, -> IDLE.
REQ-026 DROP with mem_ack=1, branch=0: discard mem_data, -> IDLE; fetch_pc SHALL be unchanged.
REQ-027 DROP with branch=1, mem_ack=0: fetch_pc <= branch_addr, stay DROP.
REQ-028 branch and inst_take in the same cycle: branch wins; the pop is subsumed by the flush.
REQ-029 inst SHALL read 16'h0000 when inst_valid=0.

Reset
REQ-030 On rst=1 at an edge: state IDLE, queue empty, fetch_pc=0, mem_addr=0, mem_req=0, inst_valid=0, inst=0, all inputs ignored.
REQ-031 Reset mid-request SHALL abandon the request; a mem_ack in the reset cycle SHALL be ignored.
REQ-032 The first request (addr 0x00) SHALL be issued in the 2nd cycle after rst falls.

Configuration
REQ-033 Macro IFETCH8_PREFETCH_EN defined: queue depth 2 as above.
REQ-034 Macro IFETCH8_PREFETCH_EN undefined: queue depth 1; requests are issued only when queue empty and none outstanding; all other rules unchanged.

Verification
REQ-035 Reset release, mem_ack returned 1 cycle after each mem_req, words 0x1E05/0x0012: requests at addrs 0x00 then 0x01; inst=0x1E05 with inst_valid=1 one cycle after the first ack.
REQ-036 inst_take held 0, memory always acks: exactly 2 words queued, then mem_req stays 0 (1 word if macro undefined).
REQ-037 fetch_pc=0xFF, ack received: fetch_pc becomes 0x00 and the next mem_addr is 0x00.
REQ-038 branch to 0x40 in WAIT, ack delayed 3 cycles: late word discarded, inst_valid=0, next request at 0x40.
REQ-039 branch to 0x80 in the same cycle as mem_ack and inst_take with 2 words queued: queue empty, data dropped, next mem_addr 0x80.
REQ-040 rst asserted in WAIT with mem_ack=1: all outputs reset values, no word queued.

Source files
------------

// File: rtl/ifetch8.sv
`default_nettype none
// ============================================================================
// Module   : ifetch8
// Purpose  : Instruction prefetch unit: request FSM + small FIFO in front of the
//            core IR. Define IFETCH8_PREFETCH_EN for a 2-entry queue (else 1).
// Revision : 1.0 - initial release
// ============================================================================
module ifetch8 (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        inst_valid,
    output logic [15:0] inst,
    input  logic        inst_take,
    input  logic        branch,
    input  logic [7:0]  branch_addr,
    output logic [7:0]  fetch_pc
);

`ifdef IFETCH8_PREFETCH_EN
    localparam logic [1:0] c_DEPTH = 2'd2;
`else
    localparam logic [1:0] c_DEPTH = 2'd1;
`endif

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic [15:0] r_q0;
    logic [15:0] r_q1;
    logic [15:0] w_q0_next;
    logic [15:0] w_q1_next;
    logic [7:0]  r_pc;
    logic [7:0]  r_addr;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;

    // Requests are only made from IDLE, so the outstanding term of the credit is zero here.
    assign w_issue = (r_state == c_IDLE) && !branch && (r_count < c_DEPTH);
    assign w_push  = (r_state == c_WAIT) && mem_ack && !branch;
    assign w_pop   = inst_take && (r_count != 2'd0) && !branch;

    always_comb begin
        w_q0_next    = r_q0;
        w_q1_next    = r_q1;
        w_count_next = r_count;
        if (w_pop) begin
            w_q0_next    = r_q1;
            w_count_next = r_count - 2'd1;
        end
        if (w_push) begin
            if (w_count_next == 2'd0) begin
                w_q0_next = mem_data;
            end else begin
                w_q1_next = mem_data;
            end
            w_count_next = w_count_next + 2'd1;
        end
        if (branch) begin
            w_count_next = 2'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (w_issue) w_state_next = c_WAIT;
            c_WAIT: begin
                if (mem_ack) begin
                    w_state_next = c_IDLE;
                end else if (branch) begin
                    w_state_next = c_DROP;
                end
            end
            c_DROP: if (mem_ack) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_count <= 2'd0;
            r_q0    <= 16'h0000;
            r_q1    <= 16'h0000;
            r_pc    <= 8'h00;
            r_addr  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_q0    <= w_q0_next;
            r_q1    <= w_q1_next;
            if (branch) begin
                r_pc <= branch_addr;
            end else if (w_push) begin
                r_pc <= r_pc + 8'd1;
            end
            if (w_issue) begin
                r_addr <= r_pc;
            end
        end
    end

    assign mem_req    = (r_state == c_WAIT) || (r_state == c_DROP);
    assign mem_addr   = r_addr;
    assign fetch_pc   = r_pc;
    assign inst_valid = (r_count != 2'd0);
    assign inst       = inst_valid ? r_q0 : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_ifetch8.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch8
// Purpose  : Directed bench for ifetch8 with a queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch8;

`ifdef IFETCH8_PREFETCH_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_take = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  branch_addr = 8'h00;
    logic [7:0]  fetch_pc;

    int tests = 0;
    int fails = 0;
    int ack_lat = 1;
    int req_age = 0;

    ifetch8 dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_take  (inst_take),
        .branch     (branch),
        .branch_addr(branch_addr),
        .fetch_pc   (fetch_pc)
    );

    always #5 clk = ~clk;

    // Reference model: fetched words, whether a live or discarded request is open, pc.
    logic [15:0] mq[$];
    bit          m_out  = 1'b0;
    bit          m_drop = 1'b0;
    bit          live   = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_pc   = 8'h00;

    function automatic logic [15:0] memword(input logic [7:0] a);
        if (a == 8'h00) return 16'h1E05;
        if (a == 8'h01) return 16'h0012;
        return {a ^ 8'h5A, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit ack, input logic [15:0] d,
                                input bit take, input bit br, input logic [7:0] ba);
        int credit;
        bit req;
        if (r) begin
            mq.delete();
            m_out  = 1'b0;
            m_drop = 1'b0;
            m_addr = 8'h00;
            m_pc   = 8'h00;
            live   = 1'b1;
            return;
        end
        if (!live) return;
        req    = m_out || m_drop;
        credit = c_DEPTH - mq.size() - (m_out ? 1 : 0);
        if (br) begin
            mq.delete();
            m_pc = ba;
            if (req) begin
                m_drop = !ack;
                m_out  = 1'b0;
            end
        end else begin
            if (take && mq.size() > 0) void'(mq.pop_front());
            if (m_out && ack) begin
                mq.push_back(d);
                m_pc  = m_pc + 8'd1;
                m_out = 1'b0;
            end else if (m_drop && ack) begin
                m_drop = 1'b0;
            end else if (!req && credit > 0) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    // One clock: memory answers ack_lat cycles into a request; fack forces an ack.
    task automatic step(input bit take = 1'b0, input bit br = 1'b0,
                        input logic [7:0] ba = 8'h00, input bit fack = 1'b0);
        bit ack;
        bit was_req;
        bit r;
        logic [15:0] d;
        inst_take   = take;
        branch      = br;
        branch_addr = ba;
        was_req     = (mem_req === 1'b1);
        ack         = fack || (was_req && req_age >= ack_lat);
        d           = fack ? 16'hBEEF : memword(mem_addr);
        mem_ack     = ack;
        mem_data    = d;
        r           = rst;
        @(posedge clk);
        model_update(r, ack, d, take, br, ba);
        #1;
        req_age   = ((mem_req === 1'b1) && was_req && !ack) ? req_age + 1 : 0;
        inst_take = 1'b0;
        branch    = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (live) begin
            check("mem_req",    32'(mem_req),    32'(m_out || m_drop));
            check("mem_addr",   32'(mem_addr),   32'(m_addr));
            check("fetch_pc",   32'(fetch_pc),   32'(m_pc));
            check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
            check("inst",       32'(inst),       32'(mq.size() > 0 ? mq[0] : 16'h0000));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Reset release and first fetches, 1-cycle memory latency
        ack_lat = 1;
        do_reset();
        check("rst_req",   32'(mem_req),    0);
        check("rst_addr",  32'(mem_addr),   0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst",  32'(inst),       0);
        check("rst_pc",    32'(fetch_pc),   0);
        step();
        check("req0", 32'(mem_req), 1);
        check("addr0", 32'(mem_addr), 0);
        step();
        step();
        check("first_valid", 32'(inst_valid), 1);
        check("first_inst",  32'(inst), 'h1E05);
        check("first_pc",    32'(fetch_pc), 1);
        step();
        check("second_req", 32'(mem_req), (c_DEPTH == 2) ? 1 : 0);
        for (int i = 0; i < 12; i++) step();
        check("full_req",  32'(mem_req), 0);
        check("full_pc",   32'(fetch_pc), c_DEPTH);
        check("full_inst", 32'(inst), 'h1E05);
        step(1'b1);
        check("pop_inst", 32'(inst), (c_DEPTH == 2) ? 'h0012 : 0);

        // Wrap of fetch_pc at 0xFF, zero-latency memory with the core always taking
        do_reset();
        ack_lat = 0;
        step(1'b0, 1'b1, 8'hFF);
        check("br_pc", 32'(fetch_pc), 'hFF);
        step();
        check("ff_addr", 32'(mem_addr), 'hFF);
        step();
        check("wrap_pc",   32'(fetch_pc), 0);
        check("wrap_inst", 32'(inst), 'hA5FF);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found) begin
                step(1'b1);
                found = (mem_req === 1'b1);
            end
        end
        check("wrap_req",  32'(found), 1);
        check("wrap_addr", 32'(mem_addr), 0);
        for (int i = 0; i < 10; i++) step(1'b1);

        // Branch in WAIT with a late ack
        do_reset();
        ack_lat = 3;
        step();
        check("w_req", 32'(mem_req), 1);
        step(1'b0, 1'b1, 8'h40);
        check("drop_req",  32'(mem_req), 1);
        check("drop_addr", 32'(mem_addr), 0);
        check("drop_pc",   32'(fetch_pc), 'h40);
        step();
        step();
        step();
        check("late_valid", 32'(inst_valid), 0);
        check("late_req",   32'(mem_req), 0);
        step();
        check("br_req",  32'(mem_req), 1);
        check("br_addr", 32'(mem_addr), 'h40);

        // Branch + ack + take together with a full queue
        do_reset();
        ack_lat = 0;
        for (int i = 0; i < 10; i++) step();
        check("q_valid", 32'(inst_valid), 1);
        step(1'b1, 1'b1, 8'h80, 1'b1);
        check("flush_valid", 32'(inst_valid), 0);
        check("flush_inst",  32'(inst), 0);
        check("flush_pc",    32'(fetch_pc), 'h80);
        step();
        check("b80_req",  32'(mem_req), 1);
        check("b80_addr", 32'(mem_addr), 'h80);

        // Reset while waiting, with an ack in the reset cycle
        do_reset();
        ack_lat = 5;
        step();
        step();
        check("pre_req", 32'(mem_req), 1);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        check("mr_req",   32'(mem_req), 0);
        check("mr_addr",  32'(mem_addr), 0);
        check("mr_valid", 32'(inst_valid), 0);
        check("mr_inst",  32'(inst), 0);
        check("mr_pc",    32'(fetch_pc), 0);
        step();
        check("mr_req1", 32'(mem_req), 1);
        check("mr_addr1", 32'(mem_addr), 0);
        check("mr_empty", 32'(inst_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
